cheri_mem_lane_adapter: RTL and testbench



---
 rtl/cheri_mem_lane_adapter.sv | 135 +++++++++++++
 tb/tb_cheri_mem_lane_adapter.sv | 250 +++++++++++++++++++++++++
 2 files changed

// File: rtl/cheri_mem_lane_adapter.sv
// Lane adapter between a 32-bit (+tag) CHERIoT core port and a MemLanes x 32-bit
// tagged memory word. Per-request lane/mode is tracked in a small FIFO so that
// up to MaxOutstanding pipelined responses are steered back correctly.
module cheri_mem_lane_adapter #(
  parameter int unsigned  MemLanes       = 2,
  parameter int unsigned  MaxOutstanding = 2,
  localparam int unsigned MemDW          = 32 * MemLanes,
  localparam int unsigned LaneBits       = (MemLanes > 1) ? $clog2(MemLanes) : 1,
  localparam int unsigned BeW            = 4 * MemLanes,
  localparam int unsigned CntW           = $clog2(MaxOutstanding + 1)
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              core_req_i,
  output logic              core_gnt_o,
  input  logic              core_we_i,
  input  logic              core_wide_i,
  input  logic [3:0]        core_be_i,
  input  logic [31:0]       core_addr_i,
  input  logic [32:0]       core_wdata_i,
  output logic              core_rvalid_o,
  output logic [MemDW:0]    core_rdata_o,
  output logic              core_err_o,
  output logic              mem_req_o,
  input  logic              mem_gnt_i,
  output logic              mem_we_o,
  output logic [BeW-1:0]    mem_be_o,
  output logic [31:0]       mem_addr_o,
  output logic [MemDW:0]    mem_wdata_o,
  input  logic              mem_rvalid_i,
  input  logic [MemDW:0]    mem_rdata_i,
  input  logic              mem_err_i,
  output logic [CntW-1:0]   outstanding_o,
  output logic              unexp_rvalid_o
);

  localparam int unsigned PtrW = (MaxOutstanding > 1) ? $clog2(MaxOutstanding) : 1;

  logic [LaneBits-1:0] req_lane;
  logic [LaneBits-1:0] head_lane;
  logic                head_wide;
  logic                full;
  logic                empty;
  logic                push;
  logic                pop;
  logic [31:0]         lane_word;

  logic [LaneBits-1:0] lane_q [MaxOutstanding];
  logic                wide_q [MaxOutstanding];
  logic [PtrW-1:0]     wptr_q, wptr_d;
  logic [PtrW-1:0]     rptr_q, rptr_d;
  logic [CntW-1:0]     cnt_q, cnt_d;
  logic                unexp_q, unexp_d;

  // Lane index of the current request; a single-lane memory always uses lane 0.
  assign req_lane = (MemLanes == 1) ? '0 : core_addr_i[2 +: LaneBits];

  assign full  = (cnt_q == CntW'(MaxOutstanding));
  assign empty = (cnt_q == '0);
  assign push  = core_req_i & mem_gnt_i & ~full;
  assign pop   = mem_rvalid_i & ~empty;

  // Request path: zero-latency pass-through, blocked while the FIFO is full.
  assign mem_req_o  = core_req_i & ~full;
  assign core_gnt_o = mem_gnt_i & ~full;
  assign mem_addr_o = core_addr_i;
  assign mem_we_o   = core_we_i;
  assign mem_be_o   = BeW'(core_be_i) << {req_lane, 2'b00};
  // Data replicated into every lane; writes to a non-zero lane clear the granule tag.
  assign mem_wdata_o = {(req_lane == '0) & core_wdata_i[32], {MemLanes{core_wdata_i[31:0]}}};

  // Head of FIFO; an empty FIFO answers as narrow lane 0.
  assign head_lane = empty ? '0 : lane_q[rptr_q];
  assign head_wide = ~empty & wide_q[rptr_q];
  assign lane_word = mem_rdata_i[32 * head_lane +: 32];

  assign core_rvalid_o  = mem_rvalid_i;
  assign core_err_o     = mem_err_i;
  assign outstanding_o  = cnt_q;
  assign unexp_rvalid_o = unexp_q;

  // Response data: full word when wide, else selected lane with lane-0-only tag.
  always_comb begin
    core_rdata_o = '0;
    if (head_wide) begin
      core_rdata_o = mem_rdata_i;
    end else begin
      core_rdata_o[31:0] = lane_word;
      core_rdata_o[32]   = (head_lane == '0) & mem_rdata_i[MemDW];
    end
  end

  // FIFO pointer, occupancy and sticky-flag next state.
  always_comb begin
    wptr_d  = wptr_q;
    rptr_d  = rptr_q;
    cnt_d   = cnt_q;
    unexp_d = unexp_q | (mem_rvalid_i & empty);
    if (push) begin
      wptr_d = (wptr_q == PtrW'(MaxOutstanding - 1)) ? '0 : wptr_q + PtrW'(1);
    end
    if (pop) begin
      rptr_d = (rptr_q == PtrW'(MaxOutstanding - 1)) ? '0 : rptr_q + PtrW'(1);
    end
    case ({push, pop})
      2'b10:   cnt_d = cnt_q + CntW'(1);
      2'b01:   cnt_d = cnt_q - CntW'(1);
      default: cnt_d = cnt_q;
    endcase
  end

  // State registers and FIFO storage.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      cnt_q   <= '0;
      unexp_q <= 1'b0;
      for (int i = 0; i < int'(MaxOutstanding); i++) begin
        lane_q[i] <= '0;
        wide_q[i] <= 1'b0;
      end
    end else begin
      wptr_q  <= wptr_d;
      rptr_q  <= rptr_d;
      cnt_q   <= cnt_d;
      unexp_q <= unexp_d;
      if (push) begin
        lane_q[wptr_q] <= req_lane;
        wide_q[wptr_q] <= core_wide_i & ~core_we_i;
      end
    end
  end

endmodule

// File: tb/tb_cheri_mem_lane_adapter.sv
// Self-checking bench: directed scenarios plus random traffic, compared each
// cycle against a queue-based reference model of the adapter.
module tb_cheri_mem_lane_adapter;

  localparam int unsigned ML  = 4;
  localparam int unsigned MO  = 2;
  localparam int unsigned MDW = 32 * ML;
  localparam int unsigned CW  = $clog2(MO + 1);

  logic           clk = 1'b0;
  logic           rst;
  logic           core_req, core_gnt, core_we, core_wide;
  logic [3:0]     core_be;
  logic [31:0]    core_addr;
  logic [32:0]    core_wdata;
  logic           core_rvalid, core_err;
  logic [MDW:0]   core_rdata;
  logic           mem_req, mem_gnt, mem_we, mem_rvalid, mem_err;
  logic [4*ML-1:0] mem_be;
  logic [31:0]    mem_addr;
  logic [MDW:0]   mem_wdata, mem_rdata;
  logic [CW-1:0]  outstanding;
  logic           unexp_rvalid;

  always #5 clk = ~clk;

  cheri_mem_lane_adapter #(.MemLanes(ML), .MaxOutstanding(MO)) dut (
    .clk_i(clk), .rst_i(rst),
    .core_req_i(core_req), .core_gnt_o(core_gnt), .core_we_i(core_we),
    .core_wide_i(core_wide), .core_be_i(core_be), .core_addr_i(core_addr),
    .core_wdata_i(core_wdata), .core_rvalid_o(core_rvalid), .core_rdata_o(core_rdata),
    .core_err_o(core_err), .mem_req_o(mem_req), .mem_gnt_i(mem_gnt), .mem_we_o(mem_we),
    .mem_be_o(mem_be), .mem_addr_o(mem_addr), .mem_wdata_o(mem_wdata),
    .mem_rvalid_i(mem_rvalid), .mem_rdata_i(mem_rdata), .mem_err_i(mem_err),
    .outstanding_o(outstanding), .unexp_rvalid_o(unexp_rvalid)
  );

  typedef struct packed {
    logic [1:0] lane;
    logic       wide;
  } ent_t;

  ent_t mq[$];
  logic m_unexp;
  int   n_checks = 0;
  int   n_errors = 0;

  task automatic check_eq(input string tag, input logic [255:0] got, input logic [255:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic idle();
    core_req   = 1'b0; core_we = 1'b0; core_wide = 1'b0; core_be = 4'h0;
    core_addr  = 32'h0; core_wdata = 33'h0;
    mem_gnt    = 1'b0; mem_rvalid = 1'b0; mem_rdata = '0; mem_err = 1'b0;
  endtask

  // Let inputs settle and compare every output against the model.
  task automatic settle();
    logic            full;
    int              lane;
    ent_t            h;
    logic [4*ML-1:0] ebe;
    logic [MDW:0]    ewd, erd;
    #1;
    if (rst) begin
      mq.delete();
      m_unexp = 1'b0;
    end
    full = (mq.size() == MO);
    lane = int'(core_addr[3:2]);
    for (int i = 0; i < 4 * int'(ML); i++) ebe[i] = (i / 4 == lane) ? core_be[i % 4] : 1'b0;
    for (int l = 0; l < int'(ML); l++) ewd[32*l +: 32] = core_wdata[31:0];
    ewd[MDW] = (lane == 0) ? core_wdata[32] : 1'b0;
    h = (mq.size() == 0) ? ent_t'(0) : mq[0];
    erd = '0;
    if (h.wide) erd = mem_rdata;
    else begin
      erd[31:0] = mem_rdata[32 * h.lane +: 32];
      erd[32]   = (h.lane == 0) ? mem_rdata[MDW] : 1'b0;
    end
    check_eq("gnt",    256'(core_gnt),     256'(mem_gnt & ~full));
    check_eq("req",    256'(mem_req),      256'(core_req & ~full));
    check_eq("addr",   256'(mem_addr),     256'(core_addr));
    check_eq("we",     256'(mem_we),       256'(core_we));
    check_eq("be",     256'(mem_be),       256'(ebe));
    check_eq("wdata",  256'(mem_wdata),    256'(ewd));
    check_eq("rvalid", 256'(core_rvalid),  256'(mem_rvalid));
    check_eq("err",    256'(core_err),     256'(mem_err));
    check_eq("rdata",  256'(core_rdata),   256'(erd));
    check_eq("occ",    256'(outstanding),  256'(mq.size()));
    check_eq("unexp",  256'(unexp_rvalid), 256'(m_unexp));
  endtask

  // Advance one clock and update the model with what the edge commits.
  task automatic tick();
    bit   psh, pp, ux;
    ent_t e;
    psh = !rst && core_req && mem_gnt && (mq.size() < MO);
    pp  = !rst && mem_rvalid && (mq.size() > 0);
    ux  = !rst && mem_rvalid && (mq.size() == 0);
    e.lane = core_addr[3:2];
    e.wide = core_wide & ~core_we;
    @(posedge clk);
    if (pp) void'(mq.pop_front());
    if (psh) mq.push_back(e);
    if (ux) m_unexp = 1'b1;
    @(negedge clk);
  endtask

  task automatic drain();
    idle();
    mem_rvalid = 1'b1;
    repeat (MO) begin settle(); tick(); end
    idle();
  endtask

  initial begin
    m_unexp = 1'b0;
    idle();
    rst = 1'b1;
    @(negedge clk);
    settle();
    check_eq("rst_occ",   256'(outstanding),  256'(0));
    check_eq("rst_unexp", 256'(unexp_rvalid), 256'(0));
    tick();
    rst = 1'b0;

    // Back-to-back narrow reads at lane 0 then lane 1.
    idle(); core_req = 1'b1; mem_gnt = 1'b1; core_addr = 32'h100;
    settle(); tick();
    core_addr = 32'h104;
    settle(); tick();
    idle(); mem_rvalid = 1'b1;
    mem_rdata = {1'b1, 32'hDDDD_DDDD, 32'hCCCC_CCCC, 32'hBBBB_BBBB, 32'hAAAA_AAAA};
    settle();
    check_eq("nar_r0", 256'(core_rdata), 256'({1'b1, 32'hAAAA_AAAA}));
    tick();
    settle();
    check_eq("nar_r1", 256'(core_rdata), 256'({1'b0, 32'hBBBB_BBBB}));
    tick();

    // Full FIFO blocks the third request, including in the rvalid cycle.
    idle(); core_req = 1'b1; mem_gnt = 1'b1; core_addr = 32'h20;
    settle(); tick(); settle(); tick();
    settle();
    check_eq("full_gnt", 256'(core_gnt),    256'(0));
    check_eq("full_req", 256'(mem_req),     256'(0));
    check_eq("full_occ", 256'(outstanding), 256'(2));
    tick();
    mem_rvalid = 1'b1;
    settle();
    check_eq("full_gnt_rv", 256'(core_gnt), 256'(0));
    tick();
    mem_rvalid = 1'b0;
    settle();
    check_eq("full_gnt_after", 256'(core_gnt), 256'(1));
    tick();
    drain();

    // Writes: lane 2 clears the tag, lane 0 keeps it.
    idle(); core_req = 1'b1; core_we = 1'b1; mem_gnt = 1'b1;
    core_be = 4'b0011; core_addr = 32'h8; core_wdata = {1'b1, 32'h1234_5678};
    settle();
    check_eq("wr_be", 256'(mem_be),    256'(16'h0300));
    check_eq("wr_wd", 256'(mem_wdata), 256'({1'b0, {4{32'h1234_5678}}}));
    tick();
    core_addr = 32'h0;
    settle();
    check_eq("wr_tag0", 256'(mem_wdata[MDW]), 256'(1));
    tick();
    drain();

    // Wide read then narrow read at the same address.
    idle(); core_req = 1'b1; mem_gnt = 1'b1; core_addr = 32'h4; core_wide = 1'b1;
    settle(); tick();
    core_wide = 1'b0;
    settle(); tick();
    idle(); mem_rvalid = 1'b1;
    mem_rdata = {1'b1, 64'h0, 64'h1111_1111_2222_2222};
    settle();
    check_eq("wide_rd", 256'(core_rdata), 256'({1'b1, 64'h0, 64'h1111_1111_2222_2222}));
    tick();
    settle();
    check_eq("wide_nar", 256'(core_rdata), 256'({1'b0, 32'h1111_1111}));
    tick();

    // Unexpected response is sticky; reset mid-burst clears everything at once.
    idle(); mem_rvalid = 1'b1;
    settle(); tick();
    idle();
    settle();
    check_eq("unexp_set", 256'(unexp_rvalid), 256'(1));
    tick();
    core_req = 1'b1; mem_gnt = 1'b1;
    settle(); tick(); settle(); tick();
    idle();
    settle();
    check_eq("unexp_sticky", 256'(unexp_rvalid), 256'(1));
    rst = 1'b1;
    settle();
    check_eq("rst_mid_occ",   256'(outstanding),  256'(0));
    check_eq("rst_mid_unexp", 256'(unexp_rvalid), 256'(0));
    tick();
    rst = 1'b0;

    // Error on the second of two responses only.
    idle(); core_req = 1'b1; mem_gnt = 1'b1;
    settle(); tick(); settle(); tick();
    idle(); mem_rvalid = 1'b1;
    settle();
    check_eq("err_first", 256'(core_err), 256'(0));
    tick();
    mem_err = 1'b1;
    settle();
    check_eq("err_second", 256'(core_err), 256'(1));
    tick();
    idle();
    settle();
    check_eq("err_idle", 256'(core_err),    256'(0));
    check_eq("err_occ",  256'(outstanding), 256'(0));
    tick();

    // Random traffic against the model.
    for (int n = 0; n < 600; n++) begin
      core_req   = 1'($urandom);
      core_we    = 1'($urandom);
      core_wide  = 1'($urandom);
      core_be    = 4'($urandom);
      core_addr  = $urandom;
      core_wdata = {1'($urandom), $urandom};
      mem_gnt    = 1'($urandom);
      mem_rvalid = ($urandom_range(2) == 0);
      mem_err    = ($urandom_range(7) == 0);
      mem_rdata  = {1'($urandom), $urandom, $urandom, $urandom, $urandom};
      rst        = ($urandom_range(63) == 0);
      settle();
      tick();
    end
    rst = 1'b0;

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
